// File: rtl/ins_encoder.sv
// Instruction encoder: turns decoded request fields into 32-bit MIPS-style words and
// queues them in a 4-entry FIFO with a running program counter for the head word.
// Optional build macro INS_ENC_LOADUSE_NOP_EN adds load-use tracking that inserts a nop
// between a lw and a following word that reads the loaded register.
module ins_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ins,
  output logic [31:0] out_pc,
  output logic [2:0]  out_level,
  output logic        err_illegal
);

  localparam int unsigned Depth = 4;
  localparam logic [31:0] PcReset = 32'h0000_3000;

  logic [31:0] mem_q [Depth];
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [31:0] pc_q, pc_d;
  logic        err_q;

  logic [31:0] enc_word;
  logic        legal;
  logic        accept;
  logic        push_ok;
  logic        pop;
  logic [1:0]  push_n;
  logic [31:0] word0;
  logic [31:0] word1;
  logic [1:0]  wr_ptr_p1;

  // Encode the requested kind; fields not used by the kind are simply not referenced.
  always_comb begin
    enc_word = 32'h0;
    legal    = 1'b1;
    case (in_kind)
      4'd0:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h20};
      4'd1:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h22};
      4'd2:    enc_word = {6'h00, in_rs, 15'h0, 6'h08};
      4'd3:    enc_word = {6'h0D, in_rs, in_rt, in_imm};
      4'd4:    enc_word = {6'h23, in_rs, in_rt, in_imm};
      4'd5:    enc_word = {6'h2B, in_rs, in_rt, in_imm};
      4'd6:    enc_word = {6'h04, in_rs, in_rt, in_imm};
      4'd7:    enc_word = {6'h0F, 5'h00, in_rt, in_imm};
      4'd8:    enc_word = {6'h03, in_target};
      4'd9:    enc_word = 32'h0;
      default: legal = 1'b0;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign push_ok   = accept && legal;
  assign pop       = out_valid && out_ready;
  assign wr_ptr_p1 = wr_ptr_q + 2'd1;

`ifdef INS_ENC_LOADUSE_NOP_EN
  logic       flag_q;
  logic [4:0] flag_rt_q;
  logic       reads_rs;
  logic       reads_rt;
  logic       hazard;

  // Which register fields the incoming kind actually reads.
  always_comb begin
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    case (in_kind)
      4'd0, 4'd1, 4'd5, 4'd6: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
      end
      4'd2, 4'd3, 4'd4: reads_rs = 1'b1;
      default: ;
    endcase
  end

  assign hazard   = flag_q && ((reads_rs && (in_rs == flag_rt_q)) ||
                               (reads_rt && (in_rt == flag_rt_q)));
  // Two free slots are kept so a nop plus the word always fit.
  assign in_ready = (count_q <= 3'd2);
  assign push_n   = !push_ok ? 2'd0 : (hazard ? 2'd2 : 2'd1);
  assign word0    = hazard ? 32'h0 : enc_word;
  assign word1    = enc_word;

  // Track the last pushed word: flagged only when it is a lw with a nonzero rt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q    <= 1'b0;
      flag_rt_q <= 5'h0;
    end else if (push_ok) begin
      flag_q    <= (in_kind == 4'd4) && (in_rt != 5'h0);
      flag_rt_q <= in_rt;
    end
  end
`else
  assign in_ready = (count_q < 3'd4);
  assign push_n   = push_ok ? 2'd1 : 2'd0;
  assign word0    = enc_word;
  assign word1    = enc_word;
`endif

  // Next-state for pointers, occupancy and pc; pc advances only when a word leaves.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q + push_n;
    count_d  = count_q + {1'b0, push_n} - {2'b00, pop};
    pc_d     = pc_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
      pc_d     = pc_q + 32'd4;
    end
  end

  // FIFO storage, pointers, pc and the illegal-kind pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= 32'h0;
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      pc_q     <= PcReset;
      err_q    <= 1'b0;
    end else begin
      if (push_n != 2'd0) mem_q[wr_ptr_q] <= word0;
      if (push_n == 2'd2) mem_q[wr_ptr_p1] <= word1;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      err_q    <= accept && !legal;
    end
  end

  assign out_valid   = (count_q != 3'd0);
  assign out_ins     = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign out_pc      = pc_q;
  assign out_level   = count_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_ins_encoder.sv
// Self-checking bench for ins_encoder: directed literal cases plus a randomized run
// compared every cycle against a queue-based model.
module tb_ins_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic [2:0]  out_level;
  logic        err_illegal;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

`ifdef INS_ENC_LOADUSE_NOP_EN
  localparam int RdyLim = 3;
`else
  localparam int RdyLim = 4;
`endif

  always #5 clk = ~clk;

  ins_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_kind     (in_kind),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_imm      (in_imm),
    .in_target   (in_target),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ins     (out_ins),
    .out_pc      (out_pc),
    .out_level   (out_level),
    .err_illegal (err_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] k, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [15:0] imm, input logic [25:0] tg);
    case (k)
      4'd0:    return {6'h00, rs, rt, rd, 5'h00, 6'h20};
      4'd1:    return {6'h00, rs, rt, rd, 5'h00, 6'h22};
      4'd2:    return {6'h00, rs, 15'h0, 6'h08};
      4'd3:    return {6'h0D, rs, rt, imm};
      4'd4:    return {6'h23, rs, rt, imm};
      4'd5:    return {6'h2B, rs, rt, imm};
      4'd6:    return {6'h04, rs, rt, imm};
      4'd7:    return {6'h0F, 5'h00, rt, imm};
      4'd8:    return {6'h03, tg};
      default: return 32'h0;
    endcase
  endfunction

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] pc_m = 32'h3000;
  bit          err_m = 1'b0;
`ifdef INS_ENC_LOADUSE_NOP_EN
  bit          flag_m = 1'b0;
  logic [4:0]  frt_m = 5'h0;
  function automatic bit reads_reg(input logic [3:0] k, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic [4:0] r);
    bit rs_rd, rt_rd;
    rs_rd = (k <= 4'd6);
    rt_rd = (k == 4'd0) || (k == 4'd1) || (k == 4'd5) || (k == 4'd6);
    return (rs_rd && rs == r) || (rt_rd && rt == r);
  endfunction
`endif

  // Model update on each clock edge / reset
  initial begin
    bit acc, popm;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        pc_m  = 32'h3000;
        err_m = 1'b0;
`ifdef INS_ENC_LOADUSE_NOP_EN
        flag_m = 1'b0;
        frt_m  = 5'h0;
`endif
      end else begin
        acc  = (in_valid === 1'b1) && (mq.size() < RdyLim);
        popm = (mq.size() != 0) && (out_ready === 1'b1);
        if (popm) begin
          void'(mq.pop_front());
          pc_m = pc_m + 32'd4;
        end
        err_m = acc && (in_kind > 4'd9);
        if (acc && in_kind <= 4'd9) begin
`ifdef INS_ENC_LOADUSE_NOP_EN
          if (flag_m && reads_reg(in_kind, in_rs, in_rt, frt_m)) mq.push_back(32'h0);
          flag_m = (in_kind == 4'd4) && (in_rt != 5'h0);
          frt_m  = in_rt;
`endif
          mq.push_back(enc(in_kind, in_rs, in_rt, in_rd, in_imm, in_target));
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("m_level", {29'h0, out_level}, mq.size());
        chk("m_valid", {31'h0, out_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
        chk("m_ins", out_ins, (mq.size() != 0) ? mq[0] : 32'h0);
        chk("m_pc", out_pc, pc_m);
        chk("m_ready", {31'h0, in_ready}, (mq.size() < RdyLim) ? 32'd1 : 32'd0);
        chk("m_err", {31'h0, err_illegal}, {31'h0, err_m});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tg);
    in_valid  = 1'b1;
    in_kind   = k;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_imm    = imm;
    in_target = tg;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    chk(name, out_ins, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_ld [$];
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_kind = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'h0; in_target = 26'h0;
    #12;
    chk("rst_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_level", {29'h0, out_level}, 32'd0);
    chk("rst_pc", out_pc, 32'h0000_3000);
    chk("rst_ins", out_ins, 32'h0);
    chk("rst_err", {31'h0, err_illegal}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    // add rs=1 rt=2 rd=3
    push(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step();
    in_valid = 1'b0;
    chk("add_valid", {31'h0, out_valid}, 32'd1);
    chk("add_ins", out_ins, 32'h0022_1820);
    chk("add_pc", out_pc, 32'h0000_3000);

    // ori then jal with consumer always ready
    do_reset();
    out_ready = 1'b1;
    push(4'd3, 5'd0, 5'd8, 5'd0, 16'h1234, 26'h0);
    step();
    push(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000C00);
    chk("ori_ins", out_ins, 32'h3408_1234);
    chk("ori_pc", out_pc, 32'h0000_3000);
    step();
    in_valid = 1'b0;
    chk("jal_ins", out_ins, 32'h0C00_0C00);
    chk("jal_pc", out_pc, 32'h0000_3004);
    step();
    out_ready = 1'b0;
    chk("drain_level", {29'h0, out_level}, 32'd0);
    chk("drain_pc", out_pc, 32'h0000_3008);

    // fill to capacity with the consumer stalled
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(4'd3, 5'd0, 5'd0, 5'd0, 16'(i), 26'h0);
      step();
    end
    in_valid = 1'b0;
    chk("full_level", {29'h0, out_level}, RdyLim);
    chk("full_ready", {31'h0, in_ready}, 32'd0);
    pop_check("full_head", 32'h3400_0000);
    chk("after_pop_ready", {31'h0, in_ready}, 32'd1);
    for (int i = 1; i < RdyLim; i++) pop_check("fifo_order", 32'h3400_0000 + i);

    // illegal kind
    do_reset();
    push(4'd12, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    chk("ill_ready", {31'h0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("ill_err", {31'h0, err_illegal}, 32'd1);
    chk("ill_level", {29'h0, out_level}, 32'd0);
    step();
    chk("ill_err_clr", {31'h0, err_illegal}, 32'd0);

    // lw rt=5 followed by add reading r5
    do_reset();
    push(4'd4, 5'd0, 5'd5, 5'd0, 16'h0004, 26'h0);
    step();
    push(4'd0, 5'd5, 5'd0, 5'd6, 16'h0, 26'h0);
    step();
    in_valid = 1'b0;
    exp_ld.push_back(32'h8C05_0004);
`ifdef INS_ENC_LOADUSE_NOP_EN
    exp_ld.push_back(32'h0000_0000);
`endif
    exp_ld.push_back(32'h00A0_3020);
    chk("ld_level", {29'h0, out_level}, exp_ld.size());
    foreach (exp_ld[i]) pop_check("ld_seq", exp_ld[i]);

    // reset with words queued and pc advanced
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(4'd3, 5'd1, 5'd2, 5'd0, 16'(i), 26'h0);
      step();
    end
    in_valid = 1'b0;
    pop_check("pre_rst_head", 32'h3422_0000);
    chk("pre_rst_pc", out_pc, 32'h0000_3004);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", {31'h0, out_valid}, 32'd0);
    chk("async_pc", out_pc, 32'h0000_3000);
    chk("async_level", {29'h0, out_level}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    push(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step();
    in_valid = 1'b0;
    chk("post_rst_ins", out_ins, 32'h0022_1820);
    chk("post_rst_pc", out_pc, 32'h0000_3000);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end else begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_kind   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
        in_rs     = 5'($urandom_range(0, 7));
        in_rt     = 5'($urandom_range(0, 7));
        in_rd     = 5'($urandom);
        in_imm    = 16'($urandom);
        in_target = 26'($urandom);
        out_ready = ($urandom_range(0, 1) == 1);
        step();
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
